game_link_msg: RTL and testbench

GAME_LINK_MSG -- requirements
Module: game_link_msg

---
 rtl/game_link_msg_pkg.sv | 20 ++
 rtl/game_link_msg_if.sv | 31 +++
 rtl/game_link_msg_fifo.sv | 57 +++++
 rtl/game_link_msg.sv | 146 ++++++++++++++
 tb/tb_game_link_msg.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_link_msg_pkg.sv
// rtl/game_link_msg_pkg.sv - shared constants, TX state encoding and helpers for the game link block
package game_link_msg_pkg;

    localparam int DEF_DATA_W = 8;

    // Default message characters for "local" and "remote" style events.
    localparam logic [7:0] CHAR_L = 8'h4C;
    localparam logic [7:0] CHAR_R = 8'h52;

    typedef logic [0:0] tx_state_t;
    localparam tx_state_t TX_IDLE = 1'b0;
    localparam tx_state_t TX_SEND = 1'b1;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {5'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/game_link_msg_if.sv
// rtl/game_link_msg_if.sv - UART-side handshake bundle between the link block and the UART FIFOs
interface game_link_msg_if
    import game_link_msg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              tx_full;
    logic              wr_uart;
    logic [DATA_W-1:0] w_data;
    logic              rx_empty;
    logic [DATA_W-1:0] r_data;
    logic              rd_uart;

    modport master (
        input  tx_full,
        output wr_uart,
        output w_data,
        input  rx_empty,
        input  r_data,
        output rd_uart
    );

    modport slave (
        output tx_full,
        input  wr_uart,
        input  w_data,
        output rx_empty,
        output r_data,
        input  rd_uart
    );
endinterface

// File: rtl/game_link_msg_fifo.sv
// rtl/game_link_msg_fifo.sv - msg_fifo: small synchronous FIFO with full/empty and same-cycle push/pop
module msg_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/game_link_msg.sv
// rtl/game_link_msg.sv - event-to-character link: local edges queued to UART TX, RX characters decoded to remote events
module game_link_msg
    import game_link_msg_pkg::*;
#(
    parameter int N_EVT   = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int Q_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_EVT-1:0]        evt_in,
    input  logic [N_EVT*DATA_W-1:0] evt_code,
    game_link_msg_if.master         uart,
    output logic [N_EVT-1:0]        remote_evt,
    output logic                    rx_err,
    output logic [DATA_W-1:0]       last_rx,
    output logic [7:0]              coal_cnt
);
    logic [N_EVT-1:0]  evt_prev;
    logic [N_EVT-1:0]  pending;
    logic [N_EVT-1:0]  redo;
    logic [N_EVT-1:0]  rise;
    logic [N_EVT-1:0]  grant;
    logic [N_EVT-1:0]  coal;
    logic [N_EVT-1:0]  match;
    logic [N_EVT-1:0]  remote_q;
    logic [3:0]        coal_n;
    logic              armed;
    logic              q_full;
    logic              q_empty;
    logic              q_push;
    logic              q_pop;
    logic [DATA_W-1:0] q_din;
    logic [DATA_W-1:0] q_head;
    logic [DATA_W-1:0] w_hold;
    tx_state_t         state;
    logic              rd_q;
    logic              rx_err_q;

    // armed stays low for the first cycle after reset so a level already high is history, not an edge.
    assign rise = evt_in & ~evt_prev & {N_EVT{armed}};

    always_comb begin
        grant = '0;
        q_din = '0;
        for (int i = N_EVT - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                q_din    = evt_code[i*DATA_W +: DATA_W];
            end
        end
        if (q_full) begin
            grant = '0;
        end
    end

    assign q_push = |grant;
    assign coal   = rise & pending & ~grant;

    always_comb begin
        coal_n = '0;
        for (int i = 0; i < N_EVT; i++) begin
            coal_n = coal_n + {3'b0, coal[i]};
        end
    end

    // An edge landing on the channel being granted is parked in redo and re-pends one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_prev <= '0;
            armed    <= 1'b0;
            pending  <= '0;
            redo     <= '0;
            coal_cnt <= '0;
        end else begin
            evt_prev <= evt_in;
            armed    <= 1'b1;
            pending  <= (pending & ~grant) | (rise & ~grant) | redo;
            redo     <= rise & grant;
            coal_cnt <= sat_add8(coal_cnt, coal_n);
        end
    end

    msg_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (Q_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .din   (q_din),
        .pop   (q_pop),
        .dout  (q_head),
        .full  (q_full),
        .empty (q_empty)
    );

    assign q_pop        = (state == TX_SEND) && !uart.tx_full && !rst;
    assign uart.wr_uart = q_pop;
    assign uart.w_data  = q_pop ? q_head : w_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= TX_IDLE;
            w_hold <= '0;
        end else begin
            case (state)
                TX_IDLE: if (!q_empty && !uart.tx_full) state <= TX_SEND;
                TX_SEND: if (q_pop) state <= TX_IDLE;
                default: state <= TX_IDLE;
            endcase
            if (q_pop) begin
                w_hold <= q_head;
            end
        end
    end

    assign uart.rd_uart = !uart.rx_empty && !rd_q && armed && !rst;

    always_comb begin
        match = '0;
        for (int i = 0; i < N_EVT; i++) begin
            match[i] = (evt_code[i*DATA_W +: DATA_W] == uart.r_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q     <= 1'b0;
            remote_q <= '0;
            rx_err_q <= 1'b0;
            last_rx  <= '0;
        end else begin
            rd_q     <= uart.rd_uart;
            remote_q <= uart.rd_uart ? match : '0;
            rx_err_q <= uart.rd_uart && (match == '0);
            if (uart.rd_uart) begin
                last_rx <= uart.r_data;
            end
        end
    end

    assign remote_evt = rst ? '0 : remote_q;
    assign rx_err     = rx_err_q && !rst;
endmodule

// File: tb/tb_game_link_msg.sv
// tb/tb_game_link_msg.sv - self-checking bench for game_link_msg
module tb_game_link_msg;
    import game_link_msg_pkg::*;

    localparam int NE = 8;
    localparam int DW = 8;
    localparam int QD = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NE-1:0]     evt_in;
    logic [NE*DW-1:0]  evt_code;
    logic [NE-1:0]     remote_evt;
    logic              rx_err;
    logic [DW-1:0]     last_rx;
    logic [7:0]        coal_cnt;

    always #5 clk = ~clk;

    game_link_msg_if #(.DATA_W(DW)) uart();

    game_link_msg #(
        .N_EVT   (NE),
        .DATA_W  (DW),
        .Q_DEPTH (QD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .evt_in     (evt_in),
        .evt_code   (evt_code),
        .uart       (uart),
        .remote_evt (remote_evt),
        .rx_err     (rx_err),
        .last_rx    (last_rx),
        .coal_cnt   (coal_cnt)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [7:0]  code [NE];
    logic [7:0]  rxq [$];
    logic [7:0]  wlog [$];
    int          wcyc [$];
    logic        prev_wr = 1'b0;
    logic        prev_rd = 1'b0;
    logic        post_rst = 1'b0;
    logic        rd_now = 1'b0;
    logic [7:0]  prev_char = '0;
    logic [7:0]  last_sent = '0;
    logic [7:0]  exp_last_rx = '0;
    int          err_seen = 0;
    int          ch1_seen = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic sync_rx();
        uart.rx_empty = (rxq.size() == 0);
        uart.r_data   = (rxq.size() != 0) ? rxq[0] : 8'h00;
    endtask

    // Per-cycle reference: UART strobe rules, RX decode one cycle after the read, TX output rules.
    task automatic monitor();
        logic          exp_rd;
        logic [NE-1:0] exp_evt;
        exp_rd = !uart.rx_empty && !prev_rd && !rst && !post_rst;
        check_eq("rd_uart", uart.rd_uart, exp_rd);
        exp_evt = '0;
        if (prev_rd && !rst) begin
            for (int i = 0; i < NE; i++) exp_evt[i] = (code[i] == prev_char);
        end
        check_eq("remote_evt", remote_evt, exp_evt);
        check_eq("rx_err", rx_err, prev_rd && !rst && (exp_evt == '0));
        if (prev_rd) exp_last_rx = prev_char;
        check_eq("last_rx", last_rx, exp_last_rx);
        if (rx_err) err_seen++;
        if (remote_evt[1]) ch1_seen++;
        if (rst || post_rst) check_eq("wr_in_reset", uart.wr_uart, 1'b0);
        if (uart.wr_uart) begin
            check_eq("wr_while_full", uart.tx_full, 1'b0);
            check_eq("wr_gap", prev_wr, 1'b0);
            wlog.push_back(uart.w_data);
            wcyc.push_back(cyc);
            last_sent = uart.w_data;
        end else begin
            check_eq("w_data_hold", uart.w_data, last_sent);
        end
        prev_wr   = uart.wr_uart;
        prev_rd   = exp_rd;
        prev_char = uart.r_data;
        rd_now    = exp_rd;
        if (rst) begin
            exp_last_rx = '0;
            last_sent   = '0;
            prev_rd     = 1'b0;
            prev_wr     = 1'b0;
        end
        post_rst = rst;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (rd_now && rxq.size() != 0) void'(rxq.pop_front());
        sync_rx();
        cyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic int count_code(input logic [7:0] c);
        int n = 0;
        foreach (wlog[k]) if (wlog[k] == c) n++;
        return n;
    endfunction

    int ord [6] = '{5, 3, 0, 4, 1, 2};
    int exp_q [$];
    int tail [$];
    int t0;
    int rises [NE];
    int total_rises;
    logic [7:0] ch;

    initial begin
        code[0] = CHAR_L; code[1] = CHAR_R; code[2] = 8'h43; code[3] = 8'h44;
        code[4] = 8'h45;  code[5] = 8'h46;  code[6] = 8'h47; code[7] = 8'h48;
        for (int i = 0; i < NE; i++) evt_code[i*DW +: DW] = code[i];
        rst = 1'b1;
        evt_in = '0;
        uart.tx_full = 1'b0;
        sync_rx();
        do_reset();
        check_eq("reset_coal", coal_cnt, 8'h00);
        check_eq("reset_last_rx", last_rx, 8'h00);
        check_eq("reset_w_data", uart.w_data, 8'h00);
        run(2);

        // Single edge: latency 3, character 'L'
        wlog.delete(); wcyc.delete();
        t0 = cyc;
        evt_in[0] = 1'b1;
        run(8);
        check_eq("t1_count", wlog.size(), 1);
        if (wlog.size() > 0) begin
            check_eq("t1_latency", wcyc[0] - t0, 3);
            check_eq("t1_data", wlog[0], CHAR_L);
        end
        evt_in = '0;
        run(2);

        // Two simultaneous edges: L then R, no coalescing
        wlog.delete();
        evt_in[1:0] = 2'b11;
        run(12);
        check_eq("t2_count", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check_eq("t2_first", wlog[0], CHAR_L);
            check_eq("t2_second", wlog[1], CHAR_R);
        end
        check_eq("t2_coal", coal_cnt, 0);
        evt_in = '0;

        // Backpressure: 6 channel edges with TX blocked, then drain in arbiter order
        do_reset(); run(2);
        wlog.delete();
        uart.tx_full = 1'b1;
        for (int k = 0; k < 6; k++) begin
            evt_in[ord[k]] = 1'b1;
            run(3);
        end
        check_eq("t3_no_wr", wlog.size(), 0);
        check_eq("t3_q_full", dut.u_fifo.full, 1'b1);
        check_eq("t3_pending", dut.pending, 8'b0000_0110);
        exp_q.delete(); tail.delete();
        for (int k = 0; k < QD; k++) exp_q.push_back(ord[k]);
        for (int k = QD; k < 6; k++) tail.push_back(ord[k]);
        tail.sort();
        foreach (tail[k]) exp_q.push_back(tail[k]);
        uart.tx_full = 1'b0;
        run(30);
        check_eq("t3_count", wlog.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < wlog.size()) check_eq("t3_order", wlog[k], code[exp_q[k]]);
        end
        evt_in = '0;
        run(2);

        // Coalescing on channel 2 while pending, then saturation of the counter
        do_reset(); run(2);
        wlog.delete();
        uart.tx_full = 1'b1;
        foreach (ord[k]) begin
            if (ord[k] != 2 && ord[k] != 5) begin
                evt_in[ord[k]] = 1'b1;
                run(3);
            end
        end
        for (int k = 0; k < 3; k++) begin
            evt_in[2] = 1'b1; run(2);
            evt_in[2] = 1'b0; run(2);
        end
        check_eq("t4_coal2", coal_cnt, 8'd2);
        for (int k = 0; k < 260; k++) begin
            evt_in[2] = 1'b1; run(2);
            evt_in[2] = 1'b0; run(2);
        end
        check_eq("t4_coal_sat", coal_cnt, 8'hFF);
        uart.tx_full = 1'b0;
        run(30);
        check_eq("t4_count", wlog.size(), 5);
        check_eq("t4_ch2_once", count_code(code[2]), 1);
        evt_in = '0;
        run(2);

        // RX decode: channel-1 code then an unknown character
        err_seen = 0; ch1_seen = 0;
        rxq.push_back(CHAR_R); sync_rx();
        run(4);
        check_eq("t5_last_rx_r", last_rx, CHAR_R);
        rxq.push_back(8'h41); sync_rx();
        run(4);
        check_eq("t5_ch1_pulses", ch1_seen, 1);
        check_eq("t5_err_pulses", err_seen, 1);
        check_eq("t5_last_rx_a", last_rx, 8'h41);

        // Reset with queued messages and levels held high across release
        do_reset(); run(2);
        uart.tx_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            evt_in[k] = 1'b1;
            run(3);
        end
        wlog.delete();
        do_reset();
        uart.tx_full = 1'b0;
        run(20);
        check_eq("t6_no_wr", wlog.size(), 0);
        check_eq("t6_coal", coal_cnt, 0);
        check_eq("t6_w_data", uart.w_data, 8'h00);
        check_eq("t6_last_rx", last_rx, 8'h00);
        evt_in = '0;
        run(2);

        // Random traffic: every local edge is either sent or counted as coalesced
        do_reset(); run(2);
        wlog.delete();
        for (int i = 0; i < NE; i++) rises[i] = 0;
        for (int n = 0; n < 1500; n++) begin
            uart.tx_full = ($urandom_range(0, 9) < 3);
            for (int i = 0; i < NE; i++) begin
                if ($urandom_range(0, 39) == 0) begin
                    if (!evt_in[i]) rises[i]++;
                    evt_in[i] = ~evt_in[i];
                end
            end
            if ($urandom_range(0, 15) == 0 && rxq.size() < 4) begin
                ch = ($urandom_range(0, 1) == 0) ? code[$urandom_range(0, NE - 1)] : 8'($urandom);
                rxq.push_back(ch);
                sync_rx();
            end
            step();
        end
        evt_in = '0;
        uart.tx_full = 1'b0;
        run(60);
        total_rises = 0;
        for (int i = 0; i < NE; i++) begin
            total_rises += rises[i];
            check_eq("rand_ch_bound", count_code(code[i]) <= rises[i], 1'b1);
        end
        check_eq("rand_conserve", wlog.size() + int'(coal_cnt), total_rises);
        check_eq("rand_drained", dut.u_fifo.empty, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
